voice_allocator: RTL and testbench

Polyphonic voice scheduler sitting between the MIDI interpreter and a bank of NUM_VOICES phase accumulators. It accepts single note-on/note-off events with their phase increment and assigns each note to a voice slot: retrigger an already-sounding note, else take a free slot, else steal the oldest. It drives each accumulator's increment, a per-voice phase-restart pulse, and an active mask for the downstream mixer feeding I2S.

---
 rtl/synth_pkg.sv | 19 +
 rtl/voice_slot.sv | 65 ++++++
 rtl/voice_allocator.sv | 200 ++++++++++++++++++++
 tb/tb_voice_allocator.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types for the synth voice path.
// FSM states, event kinds and width defaults.
package synth_pkg;

  localparam int ACC_WIDTH_DEF  = 24;
  localparam int NOTE_WIDTH_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_COMMIT
  } state_e;

  typedef enum logic {
    EV_ON,
    EV_OFF
  } ev_e;

endpackage

// File: rtl/voice_slot.sv
// One voice slot: active flag, note, increment
// and a saturating age counter.
module voice_slot
  import synth_pkg::*;
#(
  parameter int NOTE_WIDTH = NOTE_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int AGE_WIDTH  = 8
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Load,
  input  logic                  i_Clear,
  input  logic                  i_Age,
  input  logic [NOTE_WIDTH-1:0] i_Note,
  input  logic [ACC_WIDTH-1:0]  i_Phase_Inc,
  output logic                  o_Active,
  output logic [NOTE_WIDTH-1:0] o_Note,
  output logic [ACC_WIDTH-1:0]  o_Phase_Inc,
  output logic [AGE_WIDTH-1:0]  o_Age
);

  logic                  active_q, active_d;
  logic [NOTE_WIDTH-1:0] note_q, note_d;
  logic [ACC_WIDTH-1:0]  inc_q, inc_d;
  logic [AGE_WIDTH-1:0]  age_q, age_d;

  always_comb begin
    active_d = active_q;
    note_d   = note_q;
    inc_d    = inc_q;
    age_d    = age_q;
    if (i_Load) begin
      active_d = 1'b1;
      note_d   = i_Note;
      inc_d    = i_Phase_Inc;
      age_d    = '0;
    end else if (i_Clear) begin
      active_d = 1'b0;
      inc_d    = '0;
    end else if (i_Age && active_q && (age_q != '1)) begin
      age_d = age_q + AGE_WIDTH'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      active_q <= 1'b0;
      note_q   <= '0;
      inc_q    <= '0;
      age_q    <= '0;
    end else begin
      active_q <= active_d;
      note_q   <= note_d;
      inc_q    <= inc_d;
      age_q    <= age_d;
    end
  end

  assign o_Active    = active_q;
  assign o_Note      = note_q;
  assign o_Phase_Inc = inc_q;
  assign o_Age       = age_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: retrigger, else free
// slot, else steal the oldest sounding voice.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int NOTE_WIDTH = NOTE_WIDTH_DEF,
  parameter int AGE_WIDTH  = 8
) (
  input  logic                             i_Clk,
  input  logic                             i_Reset,
  input  logic                             i_Note_On,
  input  logic                             i_Note_Off,
  input  logic [NOTE_WIDTH-1:0]            i_Note,
  input  logic [ACC_WIDTH-1:0]             i_Phase_Inc,
  output logic                             o_Ready,
  output logic                             o_Drop,
  output logic                             o_Steal,
  output logic [NUM_VOICES-1:0]            o_Voice_Active,
  output logic [NUM_VOICES-1:0]            o_Voice_Load,
  output logic [NUM_VOICES*NOTE_WIDTH-1:0] o_Voice_Note,
  output logic [NUM_VOICES*ACC_WIDTH-1:0]  o_Voice_Phase_Inc
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

  state_e                state_q, state_d;
  ev_e                   ev_q, ev_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NOTE_WIDTH-1:0] note_q, note_d;
  logic [ACC_WIDTH-1:0]  inc_q, inc_d;
  logic                  mvld_q, mvld_d;
  logic [IW-1:0]         midx_q, midx_d;
  logic                  fvld_q, fvld_d;
  logic [IW-1:0]         fidx_q, fidx_d;
  logic                  ovld_q, ovld_d;
  logic [IW-1:0]         oidx_q, oidx_d;
  logic [AGE_WIDTH-1:0]  oage_q, oage_d;
  logic                  drop_q, drop_d;
  logic                  steal_q, steal_d;
  logic [NUM_VOICES-1:0] load_q, load_d;

  logic [NUM_VOICES-1:0] act;
  logic [NUM_VOICES-1:0] slot_load;
  logic [NUM_VOICES-1:0] slot_clear;
  logic                  age_en;
  logic [NOTE_WIDTH-1:0] note_v [NUM_VOICES];
  logic [ACC_WIDTH-1:0]  inc_v  [NUM_VOICES];
  logic [AGE_WIDTH-1:0]  age_v  [NUM_VOICES];

  logic                  strobe;
  logic                  cur_act;
  logic [NOTE_WIDTH-1:0] cur_note;
  logic [AGE_WIDTH-1:0]  cur_age;
  logic [IW-1:0]         tgt;

  assign strobe   = i_Note_On | i_Note_Off;
  assign cur_act  = act[idx_q];
  assign cur_note = note_v[idx_q];
  assign cur_age  = age_v[idx_q];

  always_comb begin
    state_d    = state_q;
    ev_d       = ev_q;
    idx_d      = idx_q;
    note_d     = note_q;
    inc_d      = inc_q;
    mvld_d     = mvld_q;
    midx_d     = midx_q;
    fvld_d     = fvld_q;
    fidx_d     = fidx_q;
    ovld_d     = ovld_q;
    oidx_d     = oidx_q;
    oage_d     = oage_q;
    drop_d     = 1'b0;
    steal_d    = 1'b0;
    load_d     = '0;
    slot_load  = '0;
    slot_clear = '0;
    age_en     = 1'b0;
    tgt        = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          ev_d    = i_Note_Off ? EV_OFF : EV_ON;
          note_d  = i_Note;
          inc_d   = i_Phase_Inc;
          idx_d   = '0;
          mvld_d  = 1'b0;
          fvld_d  = 1'b0;
          ovld_d  = 1'b0;
          drop_d  = i_Note_On & i_Note_Off;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        drop_d = strobe;
        if (cur_act && cur_note == note_q && !mvld_q) begin
          mvld_d = 1'b1;
          midx_d = idx_q;
        end
        if (!cur_act && !fvld_q) begin
          fvld_d = 1'b1;
          fidx_d = idx_q;
        end
        // strict compare keeps the lowest index on ties
        if (cur_act && (!ovld_q || cur_age > oage_q)) begin
          ovld_d = 1'b1;
          oidx_d = idx_q;
          oage_d = cur_age;
        end
        if (idx_q == LAST) state_d = ST_COMMIT;
        else idx_d = idx_q + IW'(1);
      end
      ST_COMMIT: begin
        drop_d  = strobe;
        state_d = ST_IDLE;
        if (ev_q == EV_ON) begin
          if (mvld_q) tgt = midx_q;
          else if (fvld_q) tgt = fidx_q;
          else tgt = oidx_q;
          steal_d        = !mvld_q && !fvld_q;
          slot_load[tgt] = 1'b1;
          load_d[tgt]    = 1'b1;
          age_en         = 1'b1;
        end else if (mvld_q) begin
          slot_clear[midx_q] = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      ev_q    <= EV_ON;
      idx_q   <= '0;
      note_q  <= '0;
      inc_q   <= '0;
      mvld_q  <= 1'b0;
      midx_q  <= '0;
      fvld_q  <= 1'b0;
      fidx_q  <= '0;
      ovld_q  <= 1'b0;
      oidx_q  <= '0;
      oage_q  <= '0;
      drop_q  <= 1'b0;
      steal_q <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      ev_q    <= ev_d;
      idx_q   <= idx_d;
      note_q  <= note_d;
      inc_q   <= inc_d;
      mvld_q  <= mvld_d;
      midx_q  <= midx_d;
      fvld_q  <= fvld_d;
      fidx_q  <= fidx_d;
      ovld_q  <= ovld_d;
      oidx_q  <= oidx_d;
      oage_q  <= oage_d;
      drop_q  <= drop_d;
      steal_q <= steal_d;
      load_q  <= load_d;
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
    voice_slot #(
      .NOTE_WIDTH(NOTE_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .AGE_WIDTH (AGE_WIDTH)
    ) u_slot (
      .i_Clk      (i_Clk),
      .i_Reset    (i_Reset),
      .i_Load     (slot_load[g]),
      .i_Clear    (slot_clear[g]),
      .i_Age      (age_en),
      .i_Note     (note_q),
      .i_Phase_Inc(inc_q),
      .o_Active   (act[g]),
      .o_Note     (note_v[g]),
      .o_Phase_Inc(inc_v[g]),
      .o_Age      (age_v[g])
    );
    assign o_Voice_Note[g*NOTE_WIDTH +: NOTE_WIDTH]     = note_v[g];
    assign o_Voice_Phase_Inc[g*ACC_WIDTH +: ACC_WIDTH] = inc_v[g];
  end

  assign o_Ready        = (state_q == ST_IDLE);
  assign o_Drop         = drop_q;
  assign o_Steal        = steal_q;
  assign o_Voice_Active = act;
  assign o_Voice_Load   = load_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: rule-level
// model compared every cycle plus directed literals.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int AW = 24;
  localparam int NW = 7;

  logic          i_Clk = 1'b0;
  logic          i_Reset = 1'b1;
  logic          i_Note_On = 1'b0;
  logic          i_Note_Off = 1'b0;
  logic [NW-1:0] i_Note = '0;
  logic [AW-1:0] i_Phase_Inc = '0;
  logic          o_Ready, o_Drop, o_Steal;
  logic [NV-1:0] o_Voice_Active, o_Voice_Load;
  logic [NV*NW-1:0] o_Voice_Note;
  logic [NV*AW-1:0] o_Voice_Phase_Inc;

  voice_allocator dut (
    .i_Clk            (i_Clk),
    .i_Reset          (i_Reset),
    .i_Note_On        (i_Note_On),
    .i_Note_Off       (i_Note_Off),
    .i_Note           (i_Note),
    .i_Phase_Inc      (i_Phase_Inc),
    .o_Ready          (o_Ready),
    .o_Drop           (o_Drop),
    .o_Steal          (o_Steal),
    .o_Voice_Active   (o_Voice_Active),
    .o_Voice_Load     (o_Voice_Load),
    .o_Voice_Note     (o_Voice_Note),
    .o_Voice_Phase_Inc(o_Voice_Phase_Inc)
  );

  always #5 i_Clk = ~i_Clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;

  // reference model state
  bit       m_act [NV];
  int       m_note[NV];
  int       m_inc [NV];
  int       m_age [NV];
  int       m_cnt;
  bit       m_off;
  int       m_lnote, m_linc;
  bit       e_drop, e_steal;
  bit [NV-1:0] e_load;

  task automatic check(string name, logic [127:0] got, logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic commit();
    int match, free, old, tgt;
    match = -1; free = -1; old = -1;
    for (int v = 0; v < NV; v++) begin
      if (m_act[v] && m_note[v] == m_lnote && match < 0) match = v;
      if (!m_act[v] && free < 0) free = v;
      if (m_act[v] && (old < 0 || m_age[v] > m_age[old])) old = v;
    end
    if (!m_off) begin
      tgt = (match >= 0) ? match : (free >= 0) ? free : old;
      e_steal = (match < 0 && free < 0);
      for (int v = 0; v < NV; v++)
        if (v != tgt && m_act[v] && m_age[v] < 255) m_age[v]++;
      m_act[tgt] = 1; m_note[tgt] = m_lnote;
      m_inc[tgt] = m_linc; m_age[tgt] = 0;
      e_load[tgt] = 1'b1;
    end else if (match >= 0) begin
      m_act[match] = 0; m_inc[match] = 0;
    end
  endtask

  task automatic model_step();
    bit strobe;
    strobe = i_Note_On | i_Note_Off;
    e_drop = 0; e_steal = 0; e_load = '0;
    if (i_Reset) begin
      for (int v = 0; v < NV; v++) begin
        m_act[v] = 0; m_note[v] = 0; m_inc[v] = 0; m_age[v] = 0;
      end
      m_cnt = 0;
    end else if (m_cnt == 0) begin
      if (strobe) begin
        m_off = i_Note_Off;
        m_lnote = int'(i_Note);
        m_linc = int'(i_Phase_Inc);
        e_drop = i_Note_On & i_Note_Off;
        m_cnt = NV + 1;
      end
    end else begin
      e_drop = strobe;
      m_cnt--;
      if (m_cnt == 0) commit();
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    model_step();
    #1;
  endtask

  always @(negedge i_Clk) begin
    if (chk_en) begin
      logic [NV-1:0]    ea;
      logic [NV*NW-1:0] en;
      logic [NV*AW-1:0] ei;
      for (int v = 0; v < NV; v++) begin
        ea[v] = m_act[v];
        en[v*NW +: NW] = NW'(m_note[v]);
        ei[v*AW +: AW] = AW'(m_inc[v]);
      end
      check("ready", 128'(o_Ready), 128'(m_cnt == 0));
      check("drop", 128'(o_Drop), 128'(e_drop));
      check("steal", 128'(o_Steal), 128'(e_steal));
      check("load", 128'(o_Voice_Load), 128'(e_load));
      check("active", 128'(o_Voice_Active), 128'(ea));
      check("notes", 128'(o_Voice_Note), 128'(en));
      check("incs", 128'(o_Voice_Phase_Inc), 128'(ei));
    end
  end

  task automatic idle(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send(bit on, bit off, int note, int inc);
    i_Note_On = on; i_Note_Off = off;
    i_Note = NW'(note); i_Phase_Inc = AW'(inc);
    tick();
    i_Note_On = 0; i_Note_Off = 0;
  endtask

  task automatic note_on(int note, int inc);
    send(1, 0, note, inc);
    idle(NV + 1);
  endtask

  task automatic do_reset();
    i_Reset = 1; tick(); i_Reset = 0;
  endtask

  initial begin
    tick();
    chk_en = 1;
    tick();
    i_Reset = 0;
    check("rst_ready", 128'(o_Ready), 128'(1));
    check("rst_active", 128'(o_Voice_Active), 128'(0));

    note_on(60, 'h00ABCD);
    check("first_active", 128'(o_Voice_Active), 128'(4'b0001));
    check("first_note", 128'(o_Voice_Note[6:0]), 128'(60));
    check("first_inc", 128'(o_Voice_Phase_Inc[23:0]), 128'('h00ABCD));
    check("first_load", 128'(o_Voice_Load), 128'(4'b0001));
    check("first_steal", 128'(o_Steal), 128'(0));
    tick();
    check("first_load_end", 128'(o_Voice_Load), 128'(0));

    note_on(62, 1); note_on(64, 2); note_on(67, 3);
    note_on(69, 4);
    check("steal_pulse", 128'(o_Steal), 128'(1));
    check("steal_load", 128'(o_Voice_Load), 128'(4'b0001));
    check("steal_active", 128'(o_Voice_Active), 128'(4'b1111));
    check("steal_note", 128'(o_Voice_Note[6:0]), 128'(69));

    do_reset();
    note_on(60, 5); note_on(62, 6);
    note_on(62, 'h111111);
    check("retrig_load", 128'(o_Voice_Load), 128'(4'b0010));
    check("retrig_active", 128'(o_Voice_Active), 128'(4'b0011));
    check("retrig_steal", 128'(o_Steal), 128'(0));
    check("retrig_inc", 128'(o_Voice_Phase_Inc[47:24]), 128'('h111111));

    send(0, 1, 62, 0); idle(NV + 1);
    check("off_active", 128'(o_Voice_Active), 128'(4'b0001));
    check("off_inc", 128'(o_Voice_Phase_Inc[47:24]), 128'(0));
    send(0, 1, 50, 0); idle(NV + 1);
    check("off_nomatch", 128'(o_Voice_Active), 128'(4'b0001));
    check("off_nodrop", 128'(o_Drop), 128'(0));

    send(1, 0, 70, 7);
    tick();
    send(1, 0, 71, 8);
    check("busy_drop", 128'(o_Drop), 128'(1));
    idle(3);
    check("busy_commit", 128'(o_Voice_Load), 128'(4'b0010));
    check("busy_note", 128'(o_Voice_Note[13:7]), 128'(70));

    send(1, 0, 72, 9);
    idle(2);
    do_reset();
    check("mid_rst_ready", 128'(o_Ready), 128'(1));
    check("mid_rst_active", 128'(o_Voice_Active), 128'(0));
    for (int k = 0; k < 8; k++) begin
      tick();
      check("mid_rst_noload", 128'(o_Voice_Load), 128'(0));
    end

    note_on(10, 1); note_on(11, 2); note_on(12, 3); note_on(13, 4);
    for (int k = 0; k < 253; k++) note_on(13, k);
    note_on(14, 5);
    check("sat_steal", 128'(o_Steal), 128'(1));
    check("sat_load", 128'(o_Voice_Load), 128'(4'b0001));

    do_reset();
    for (int k = 0; k < 4000; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      i_Reset = ($urandom_range(0, 399) == 0);
      i_Note_On = 0; i_Note_Off = 0;
      if (r < 18) i_Note_On = 1;
      else if (r < 24) i_Note_Off = 1;
      else if (r < 25) begin i_Note_On = 1; i_Note_Off = 1; end
      i_Note = NW'($urandom_range(60, 65));
      i_Phase_Inc = AW'($urandom);
      tick();
    end
    i_Reset = 0; i_Note_On = 0; i_Note_Off = 0;
    idle(NV + 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
